// File: rtl/route_cmd_ctrl_pkg.sv
// Shared opcodes and FSM state type for the multi-stop route command controller.
package route_pkg;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_GO     = 2'b01;
  localparam logic [1:0] OP_APPEND = 2'b10;
  localparam logic [1:0] OP_RSVD   = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } route_state_t;

endpackage

// File: rtl/route_cmd_ctrl_dest_fifo.sv
// Destination FIFO with flush, simultaneous push/pop and a registered head.
module dest_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);
  import route_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r, wr_ptr_r, rd_ptr_s, wr_ptr_s, wr_addr_s;
  logic [CW-1:0] count_r, count_s;
  logic [W-1:0]  head_r, head_s;
  logic          pop_s, push_s;

  // Next pointers/count; flush with push leaves exactly the new entry.
  always_comb begin
    pop_s     = 1'b0;
    push_s    = 1'b0;
    rd_ptr_s  = rd_ptr_r;
    wr_ptr_s  = wr_ptr_r;
    wr_addr_s = wr_ptr_r;
    count_s   = count_r;
    head_s    = head_r;
    if (flush) begin
      push_s    = push;
      wr_addr_s = PTR_ZERO;
      rd_ptr_s  = PTR_ZERO;
      wr_ptr_s  = push ? PTR_ONE : PTR_ZERO;
      count_s   = push ? CNT_ONE : CNT_ZERO;
    end else begin
      pop_s    = pop && (count_r != CNT_ZERO);
      push_s   = push && ((count_r != CNT_MAX) || pop_s);
      rd_ptr_s = rd_ptr_r + PW'(pop_s);
      wr_ptr_s = wr_ptr_r + PW'(push_s);
      count_s  = count_r + CW'(push_s) - CW'(pop_s);
    end
    // The head is recomputed ahead of the edge so it can be a plain register.
    if (count_s == CNT_ZERO) begin
      head_s = {W{1'b0}};
    end else if (push_s && (wr_addr_s == rd_ptr_s)) begin
      head_s = din;
    end else begin
      head_s = mem_r[rd_ptr_s];
    end
  end

  // Pointer, count and head registers plus storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= PTR_ZERO;
      wr_ptr_r <= PTR_ZERO;
      count_r  <= CNT_ZERO;
      head_r   <= {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {W{1'b0}};
    end else begin
      rd_ptr_r <= rd_ptr_s;
      wr_ptr_r <= wr_ptr_s;
      count_r  <= count_s;
      head_r   <= head_s;
      if (push_s) mem_r[wr_addr_s] <= din;
    end
  end

  assign head  = head_r;
  assign count = count_r;
  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == CNT_ZERO);

endmodule

// File: rtl/route_cmd_ctrl.sv
// Route command controller: command decode, station match FSM and blocked-path buzzer.
module route_cmd_ctrl
  import route_pkg::*;
#(
  parameter int ID_W     = 6,
  parameter int DEPTH    = 4,
  parameter int BUZZ_DIV = 12500
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ID_W+1:0]            cmd,
  input  logic                       cmd_rdy,
  output logic                       clr_cmd_rdy,
  input  logic [ID_W+1:0]            ID,
  input  logic                       ID_vld,
  output logic                       clr_ID_vld,
  input  logic                       OK2Move,
  output logic                       in_transit,
  output logic                       go,
  output logic                       buzz,
  output logic                       buzz_n,
  output logic                       arrived,
  output logic [$clog2(DEPTH+1)-1:0] route_cnt,
  output logic [ID_W-1:0]            cur_dest,
  output logic                       ovf
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int BW = $clog2(BUZZ_DIV);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1'b1);
  localparam logic [BW-1:0] BUZZ_LAST = BW'(BUZZ_DIV-1);

  route_state_t    state_r, state_s;
  logic [1:0]      op_s;
  logic [ID_W-1:0] dest_s;
  logic            stop_s, start_s, append_s, match_s, pop_s, flush_s, push_s;
  logic            fifo_full_s, fifo_empty_s;
  logic [CW-1:0]   fifo_cnt_s;
  logic [ID_W-1:0] fifo_head_s;
  logic            ovf_r, ovf_s, arrived_r;
  logic            buzz_r, buzz_n_r, buzz_act_s;
  logic [BW-1:0]   buzz_cnt_r;

  assign op_s        = cmd[ID_W+1:ID_W];
  assign dest_s      = cmd[ID_W-1:0];
  assign clr_cmd_rdy = cmd_rdy;
  assign clr_ID_vld  = ID_vld;

  // Command decode, station match, queue control and next state.
  always_comb begin
    stop_s   = 1'b0;
    start_s  = 1'b0;
    append_s = 1'b0;
    if (cmd_rdy) begin
      case (op_s)
        OP_STOP:   stop_s   = 1'b1;
        OP_GO:     start_s  = 1'b1;
        OP_APPEND: append_s = 1'b1;
        OP_RSVD:   stop_s   = 1'b0;
        default:   stop_s   = 1'b0;
      endcase
    end else begin
      stop_s = 1'b0;
    end
    match_s = (state_r == RUN) && ID_vld && !fifo_empty_s &&
              (ID[ID_W+1:ID_W] == 2'b00) && (ID[ID_W-1:0] == fifo_head_s);
    // STOP and GO override a same-cycle arrival.
    pop_s   = match_s && !stop_s && !start_s;
    flush_s = stop_s || start_s;
    push_s  = start_s || append_s;
    if (stop_s) begin
      ovf_s = 1'b0;
    end else if (append_s && fifo_full_s && !pop_s) begin
      ovf_s = 1'b1;
    end else begin
      ovf_s = ovf_r;
    end
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s || append_s) state_s = RUN;
        else                     state_s = IDLE;
      end
      RUN: begin
        if (stop_s)                                              state_s = IDLE;
        else if (pop_s && !append_s && (fifo_cnt_s == CNT_ONE))  state_s = IDLE;
        else                                                     state_s = RUN;
      end
      default: state_s = IDLE;
    endcase
  end

  dest_fifo #(
    .W     (ID_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush_s),
    .push  (push_s),
    .pop   (pop_s),
    .din   (dest_s),
    .head  (fifo_head_s),
    .count (fifo_cnt_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Route FSM, sticky overflow and arrival pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      ovf_r     <= 1'b0;
      arrived_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ovf_r     <= ovf_s;
      arrived_r <= pop_s;
    end
  end

  assign buzz_act_s = (state_r == RUN) && !OK2Move;

  // Piezo drive: starts high on activation, toggles every BUZZ_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      buzz_r     <= 1'b0;
      buzz_n_r   <= 1'b0;
      buzz_cnt_r <= {BW{1'b0}};
    end else if (!buzz_act_s) begin
      buzz_r     <= 1'b0;
      buzz_n_r   <= 1'b0;
      buzz_cnt_r <= {BW{1'b0}};
    end else if (!(buzz_r || buzz_n_r)) begin
      buzz_r     <= 1'b1;
      buzz_n_r   <= 1'b0;
      buzz_cnt_r <= {BW{1'b0}};
    end else if (buzz_cnt_r == BUZZ_LAST) begin
      buzz_r     <= ~buzz_r;
      buzz_n_r   <= buzz_r;
      buzz_cnt_r <= {BW{1'b0}};
    end else begin
      buzz_cnt_r <= buzz_cnt_r + BW'(1'b1);
    end
  end

  assign in_transit = (state_r == RUN);
  assign go         = in_transit & OK2Move;
  assign buzz       = buzz_r;
  assign buzz_n     = buzz_n_r;
  assign arrived    = arrived_r;
  assign route_cnt  = fifo_cnt_s;
  assign cur_dest   = fifo_head_s;
  assign ovf        = ovf_r;

endmodule

// File: tb/tb_route_cmd_ctrl.sv
// Scoreboard bench for route_cmd_ctrl: directed vectors push expectations, a negedge monitor checks.
module tb_route_cmd_ctrl;

  localparam logic [1:0] S = 2'b00;
  localparam logic [1:0] G = 2'b01;
  localparam logic [1:0] A = 2'b10;
  localparam logic [1:0] R = 2'b11;

  logic       clk, rst, cmd_rdy, clr_cmd_rdy, ID_vld, clr_ID_vld, OK2Move;
  logic       in_transit, go, buzz, buzz_n, arrived, ovf;
  logic [7:0] cmd, ID;
  logic [2:0] route_cnt;
  logic [5:0] cur_dest, prev_cd;

  typedef struct {
    string      nm;
    logic       cc, ci, tr, go, ov, ar, bz, bzn;
    logic [2:0] cnt;
    logic [5:0] cd;
  } exp_t;

  exp_t       exp_q[$];
  logic [5:0] arr_q[$];
  int         n_chk = 0;
  int         n_err = 0;

  route_cmd_ctrl #(.ID_W(6), .DEPTH(4), .BUZZ_DIV(4)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .ID(ID), .ID_vld(ID_vld), .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move),
    .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n), .arrived(arrived),
    .route_cnt(route_cnt), .cur_dest(cur_dest), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: arrival scoreboard plus per-cycle output snapshot.
  always @(negedge clk) begin
    exp_t e;
    if (arrived === 1'b1) begin
      if (arr_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL arrived_unexpected: got 1 expected 0 (prev dest %0h)", prev_cd);
      end else begin
        chk("arrived_dest", {26'd0, prev_cd}, {26'd0, arr_q.pop_front()});
      end
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.nm, ".clr_cmd_rdy"}, {31'd0, clr_cmd_rdy}, {31'd0, e.cc});
      chk({e.nm, ".clr_ID_vld"},  {31'd0, clr_ID_vld},  {31'd0, e.ci});
      chk({e.nm, ".in_transit"},  {31'd0, in_transit},  {31'd0, e.tr});
      chk({e.nm, ".go"},          {31'd0, go},          {31'd0, e.go});
      chk({e.nm, ".route_cnt"},   {29'd0, route_cnt},   {29'd0, e.cnt});
      chk({e.nm, ".cur_dest"},    {26'd0, cur_dest},    {26'd0, e.cd});
      chk({e.nm, ".ovf"},         {31'd0, ovf},         {31'd0, e.ov});
      chk({e.nm, ".arrived"},     {31'd0, arrived},     {31'd0, e.ar});
      chk({e.nm, ".buzz"},        {31'd0, buzz},        {31'd0, e.bz});
      chk({e.nm, ".buzz_n"},      {31'd0, buzz_n},      {31'd0, e.bzn});
    end
    prev_cd = cur_dest;
  end

  // Apply one cycle of inputs; expectations describe outputs during this same cycle.
  task automatic step(input logic rs, cr, input logic [1:0] op, input logic [5:0] dst,
                      input logic iv, input logic [7:0] id, input logic ok, m, tr,
                      input logic [2:0] cnt, input logic [5:0] cd,
                      input logic ov, ar, bz, bzn, input string nm);
    exp_t e;
    rst = rs; cmd_rdy = cr; cmd = {op, dst}; ID_vld = iv; ID = id; OK2Move = ok;
    e.nm = nm; e.cc = cr; e.ci = iv; e.tr = tr; e.go = tr & ok; e.ov = ov;
    e.ar = ar; e.bz = bz; e.bzn = bzn; e.cnt = cnt; e.cd = cd;
    exp_q.push_back(e);
    if (m) arr_q.push_back(id[5:0]);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_rdy = 1'b0; cmd = 8'h00; ID_vld = 1'b0; ID = 8'h00; OK2Move = 1'b1;
    prev_cd = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    //   rs cr op dst    iv id     ok m  tr cnt cd    ov ar bz bzn
    step(1, 1, G, 6'h0A, 1, 8'h0A, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "reset");
    step(0, 1, G, 6'h0A, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "go_0a");
    step(0, 0, S, 6'h00, 1, 8'h05, 1, 0, 1, 1, 6'h0A, 0, 0, 0, 0, "id_miss");
    step(0, 0, S, 6'h00, 1, 8'h0A, 1, 1, 1, 1, 6'h0A, 0, 0, 0, 0, "id_hit");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 1, 0, 0, "arrive_0a");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "idle_after");
    // three-stop route
    step(0, 1, G, 6'h01, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "go_01");
    step(0, 1, A, 6'h02, 0, 8'h00, 1, 0, 1, 1, 6'h01, 0, 0, 0, 0, "app_02");
    step(0, 1, A, 6'h03, 0, 8'h00, 1, 0, 1, 2, 6'h01, 0, 0, 0, 0, "app_03");
    step(0, 0, S, 6'h00, 1, 8'h41, 1, 0, 1, 3, 6'h01, 0, 0, 0, 0, "id_tagged");
    step(0, 0, S, 6'h00, 1, 8'h01, 1, 1, 1, 3, 6'h01, 0, 0, 0, 0, "hit_01");
    step(0, 0, S, 6'h00, 1, 8'h02, 1, 1, 1, 2, 6'h02, 0, 1, 0, 0, "hit_02");
    step(0, 0, S, 6'h00, 1, 8'h03, 1, 1, 1, 1, 6'h03, 0, 1, 0, 0, "hit_03");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 1, 0, 0, "route_done");
    // overflow and STOP
    step(0, 1, G, 6'h04, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "go_04");
    step(0, 1, A, 6'h05, 0, 8'h00, 1, 0, 1, 1, 6'h04, 0, 0, 0, 0, "app_05");
    step(0, 1, A, 6'h06, 0, 8'h00, 1, 0, 1, 2, 6'h04, 0, 0, 0, 0, "app_06");
    step(0, 1, A, 6'h07, 0, 8'h00, 1, 0, 1, 3, 6'h04, 0, 0, 0, 0, "app_07");
    step(0, 1, A, 6'h08, 0, 8'h00, 1, 0, 1, 4, 6'h04, 0, 0, 0, 0, "app_full");
    step(0, 1, R, 6'h09, 0, 8'h00, 1, 0, 1, 4, 6'h04, 1, 0, 0, 0, "rsvd");
    step(0, 1, S, 6'h00, 0, 8'h00, 1, 0, 1, 4, 6'h04, 1, 0, 0, 0, "stop");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "stopped");
    // blocked path buzzer
    step(0, 1, G, 6'h09, 0, 8'h00, 0, 0, 0, 0, 6'h00, 0, 0, 0, 0, "go_09_blocked");
    step(0, 0, S, 6'h00, 0, 8'h00, 0, 0, 1, 1, 6'h09, 0, 0, 0, 0, "blocked_start");
    for (int k = 0; k < 12; k++) begin
      step(0, 0, S, 6'h00, 0, 8'h00, 0, 0, 1, 1, 6'h09, 0, 0,
           ((k / 4) % 2) == 0, ((k / 4) % 2) != 0, "buzz");
    end
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 1, 1, 6'h09, 0, 0, 0, 1, "clear_go");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 1, 1, 6'h09, 0, 0, 0, 0, "buzz_off");
    step(0, 1, S, 6'h00, 0, 8'h00, 1, 0, 1, 1, 6'h09, 0, 0, 0, 0, "stop_09");
    // full queue with APPEND and arrival in the same cycle
    step(0, 1, G, 6'h10, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "go_10");
    step(0, 1, A, 6'h11, 0, 8'h00, 1, 0, 1, 1, 6'h10, 0, 0, 0, 0, "app_11");
    step(0, 1, A, 6'h12, 0, 8'h00, 1, 0, 1, 2, 6'h10, 0, 0, 0, 0, "app_12");
    step(0, 1, A, 6'h13, 0, 8'h00, 1, 0, 1, 3, 6'h10, 0, 0, 0, 0, "app_13");
    step(0, 1, A, 6'h07, 1, 8'h10, 1, 1, 1, 4, 6'h10, 0, 0, 0, 0, "full_app_hit");
    step(0, 0, S, 6'h00, 1, 8'h11, 1, 1, 1, 4, 6'h11, 0, 1, 0, 0, "hit_11");
    step(0, 0, S, 6'h00, 1, 8'h12, 1, 1, 1, 3, 6'h12, 0, 1, 0, 0, "hit_12");
    step(0, 0, S, 6'h00, 1, 8'h13, 1, 1, 1, 2, 6'h13, 0, 1, 0, 0, "hit_13");
    step(0, 1, S, 6'h00, 1, 8'h07, 1, 0, 1, 1, 6'h07, 0, 1, 0, 0, "stop_vs_hit");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "stop_no_arrive");
    // APPEND from IDLE, GO replacement, single-entry APPEND with arrival
    step(0, 1, A, 6'h30, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "app_idle");
    step(0, 1, G, 6'h20, 0, 8'h00, 1, 0, 1, 1, 6'h30, 0, 0, 0, 0, "go_20");
    step(0, 1, A, 6'h21, 1, 8'h20, 1, 1, 1, 1, 6'h20, 0, 0, 0, 0, "single_app_hit");
    step(0, 1, G, 6'h22, 1, 8'h21, 1, 0, 1, 1, 6'h21, 0, 1, 0, 0, "go_vs_hit");
    step(0, 1, A, 6'h23, 0, 8'h00, 1, 0, 1, 1, 6'h22, 0, 0, 0, 0, "app_23");
    step(0, 1, A, 6'h24, 0, 8'h00, 1, 0, 1, 2, 6'h22, 0, 0, 0, 0, "app_24");
    // reset mid-route
    step(1, 0, S, 6'h00, 0, 8'h00, 1, 0, 1, 3, 6'h22, 0, 0, 0, 0, "pre_reset");
    step(0, 0, S, 6'h00, 1, 8'h22, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "post_reset");
    step(0, 0, S, 6'h00, 0, 8'h00, 1, 0, 0, 0, 6'h00, 0, 0, 0, 0, "no_arrive");
    repeat (2) @(posedge clk);
    #1;
    chk("exp_drain", exp_q.size(), 32'd0);
    chk("arr_drain", arr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/route_cmd_ctrl.md
# route_cmd_ctrl

Command controller for the follower robot with a multi-stop route queue. It accepts go, append and stop commands from the UART command path and holds up to DEPTH destination IDs in a FIFO. It compares barcode/station IDs against the head destination and drives `in_transit`/`go` to the motion controller and the blocked-path piezo buzzer. It replaces the single-destination command controller.

## Interface
Parameters:
- `ID_W`, 6, destination ID width; command width is ID_W+2.
- `DEPTH`, 4, route queue depth (≥2, power of 2).
- `BUZZ_DIV`, 12500, cycles per buzzer half-period (≥2).

Ports:
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `cmd` in ID_W+2: `[ID_W+1:ID_W]` opcode, `[ID_W-1:0]` destination.
- `cmd_rdy` in 1: command valid from the UART wrapper.
- `clr_cmd_rdy` out 1: consume strobe for `cmd_rdy`.
- `ID` in ID_W+2: station ID from the barcode reader.
- `ID_vld` in 1: ID valid.
- `clr_ID_vld` out 1: consume strobe for `ID_vld`.
- `OK2Move` in 1: path clear (from the proximity sensor).
- `in_transit` out 1: route active.
- `go` out 1: motion enable, equal to `in_transit & OK2Move`.
- `buzz`, `buzz_n` out 1 each: piezo differential drive.
- `arrived` out 1: one-cycle pulse on each destination match.
- `route_cnt` out $clog2(DEPTH+1): queued destinations, including the head.
- `cur_dest` out ID_W: head destination; 0 when the queue is empty.
- `ovf` out 1: sticky append-overflow flag.

## Operation
- Opcodes:
  - 00 STOP: flush the queue, clear `ovf`, go to IDLE.
  - 01 GO: flush the queue, push the destination, go to RUN.
  - 10 APPEND: push the destination. If in IDLE, go to RUN. If the queue is full, drop the destination and set `ovf`.
  - 11: ignored, but still consumed.
- `clr_cmd_rdy = cmd_rdy`. It is combinational and lasts the same cycle, because every command is consumed in one cycle.
- `clr_ID_vld = ID_vld` in both states. IDs arriving in IDLE are discarded.
- FSM:
  - IDLE: `in_transit`=0.
  - RUN: `in_transit`=1.
  - RUN→IDLE when a match pops the last entry, or on STOP.
- Match condition: `ID_vld` and `ID[ID_W+1:ID_W]==0` and `ID[ID_W-1:0]==cur_dest`, in RUN. A match pops the head and pulses `arrived`. A mismatch only clears `ID_vld`.
- Buzzer:
  - Active when `in_transit & ~OK2Move`.
  - While active, a counter toggles `buzz` every BUZZ_DIV cycles, and `buzz_n = ~buzz`.
  - When inactive, the counter resets, `buzz`=0 and `buzz_n`=0.
  - Activation starts with `buzz`=1, `buzz_n`=0.
- Simultaneous `cmd_rdy` and matching `ID_vld`:
  - STOP or GO: the command wins and the match is ignored (no `arrived`). GO leaves exactly one entry, the new destination.
  - APPEND: pop and push happen in the same cycle, and the net count is unchanged. If the queue is full, the pop frees a slot, so no overflow occurs. If the popped entry was the only one, the appended entry becomes the head and the FSM stays in RUN.

## Timing
- Reset values (all outputs registered except `clr_*` and `go`):
  - FSM = IDLE, queue empty.
  - `in_transit`=0, `go`=0, `buzz`=0, `buzz_n`=0, `arrived`=0, `route_cnt`=0, `cur_dest`=0, `ovf`=0.
  - `clr_*` follow their inputs during reset.
- Reset during RUN flushes the queue on the next edge.
- Command sampled at edge N: `in_transit`, `route_cnt` and `cur_dest` update after edge N and are visible in cycle N+1.
- Match sampled at edge N: `arrived` is high for cycle N+1, and `cur_dest` shows the next entry in cycle N+1.
- `go` follows `OK2Move` combinationally while `in_transit`=1.
- Buzzer: the first toggle occurs BUZZ_DIV cycles after `buzz` rises. Period is 2·BUZZ_DIV cycles.
- FIFO pointers wrap modulo DEPTH. `route_cnt` saturates at DEPTH, and a push is never accepted when full unless a pop occurs the same cycle.

## Structure
- Package `route_pkg` holds:
  - opcode localparams `OP_STOP`, `OP_GO`, `OP_APPEND`, `OP_RSVD`;
  - the state enum `route_state_t {IDLE, RUN}`.
- Sub-module `dest_fifo`:
  - parametrised on width and depth;
  - supports push, pop and flush, including simultaneous push and pop;
  - outputs `head`, `count`, `full`, `empty`.
- The FSM, match compare and buzzer counter live in the top module.

## Test plan
- Reset, then GO dest 0x0A; ID 0x05 with `ID_vld` → `clr_ID_vld` pulses, `in_transit` stays 1. ID 0x0A → `arrived` pulses, `in_transit`=0 next cycle.
- GO 0x01, then APPEND 0x02 and 0x03 → `route_cnt`=3, `cur_dest`=1. IDs 1, 2, 3 in sequence → three `arrived` pulses, `cur_dest` steps 2→3→0, then IDLE.
- DEPTH=4: GO followed by 4 APPENDs → `route_cnt`=4, `ovf`=1. STOP → `ovf`=0, `route_cnt`=0, `in_transit`=0.
- RUN with `OK2Move`=0 and BUZZ_DIV=4 → `go`=0, `buzz` toggles every 4 cycles with `buzz_n`=~`buzz`. Set `OK2Move`=1 → `go`=1, `buzz`=`buzz_n`=0.
- Queue full, then APPEND 0x07 in the same cycle as a matching ID → count stays 4, `ovf`=0, 0x07 becomes the tail. Same cycle with STOP → queue empty, no `arrived`.
- Assert `rst` mid-route with 3 entries → all outputs at reset values after one edge; subsequent IDs are cleared without `arrived`.
